reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_if.sv | 33 +++
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the reset request inputs and the sequenced reset outputs of reset_sequencer.
//   sw_rst_req  : software reset request, active-high
//   wdt_rst_req : watchdog reset request, active-high
//   rst_out     : per-domain reset, active-high, bit 0 releases first
//   rst_done    : high once every domain is released
//   rst_cause   : cause of the last reset (00 rst_n, 01 software, 10 watchdog)
// Modports: master = requester / observer, slave = the sequencer.
interface reset_sequencer_if #(
  parameter int unsigned N_DOMAINS = 3
);
  logic                 sw_rst_req;
  logic                 wdt_rst_req;
  logic [N_DOMAINS-1:0] rst_out;
  logic                 rst_done;
  logic [1:0]           rst_cause;

  modport master (
    output sw_rst_req,
    output wdt_rst_req,
    input  rst_out,
    input  rst_done,
    input  rst_cause
  );

  modport slave (
    input  sw_rst_req,
    input  wdt_rst_req,
    output rst_out,
    output rst_done,
    output rst_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Holds N_DOMAINS reset domains asserted for HOLD_CYCLES after a reset event, then releases
// them one at a time (bit 0 first) every STAGE_DELAY cycles. Software and watchdog requests
// restart the sequence from the top.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, already synchronized to clk
//   bus   : reset_sequencer_if.slave (requests in, rst_out/rst_done/rst_cause out)
// Parameters: N_DOMAINS (1..8), HOLD_CYCLES (>=1), STAGE_DELAY (>=1).
// Build option: define RESET_SEQUENCER_CAUSE_EN to build the reset-cause register;
// without it rst_cause is tied to 00.
module reset_sequencer #(
  parameter int unsigned N_DOMAINS   = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_DELAY = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  reset_sequencer_if.slave        bus
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // The counter value seen on the edge that completes a phase: the edge after a reset
  // event is edge 1, so the phase ends when the counter already holds length - 1.
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DELAY - 1);

  typedef enum logic [1:0] {
    StHold,
    StRelease,
    StRun
  } state_e;

  state_e               r_state_q, w_state_d;
  logic [CntW-1:0]      r_cnt_q, w_cnt_d;
  logic [N_DOMAINS-1:0] r_out_q, w_out_d;
  logic                 r_done_q, w_done_d;

  logic                 w_req;
  logic [N_DOMAINS-1:0] w_out_shift;

  assign w_req = bus.sw_rst_req | bus.wdt_rst_req;

  // rst_out is always a run of ones above a run of zeros, so shifting left by one clears
  // exactly the lowest still-asserted domain.
  assign w_out_shift = r_out_q << 1;

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_out_d   = r_out_q;
    w_done_d  = r_done_q;

    if (w_req) begin
      // A request in any state (including HOLD) restarts the hold from zero.
      w_state_d = StHold;
      w_cnt_d   = '0;
      w_out_d   = '1;
      w_done_d  = 1'b0;
    end else begin
      unique case (r_state_q)
        StHold: begin
          if (r_cnt_q == HoldLast) begin
            w_cnt_d = '0;
            w_out_d = w_out_shift;
            if (w_out_shift == '0) begin
              w_state_d = StRun;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = StRelease;
            end
          end else begin
            w_cnt_d = r_cnt_q + CntW'(1);
          end
        end
        StRelease: begin
          if (r_cnt_q == StageLast) begin
            w_cnt_d = '0;
            w_out_d = w_out_shift;
            if (w_out_shift == '0) begin
              w_state_d = StRun;
              w_done_d  = 1'b1;
            end
          end else begin
            w_cnt_d = r_cnt_q + CntW'(1);
          end
        end
        StRun: begin
          w_cnt_d = '0;
        end
        default: begin
          w_state_d = StHold;
          w_cnt_d   = '0;
          w_out_d   = '1;
          w_done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= StHold;
      r_cnt_q   <= '0;
      r_out_q   <= '1;
      r_done_q  <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_out_q   <= w_out_d;
      r_done_q  <= w_done_d;
    end
  end

  assign bus.rst_out  = r_out_q;
  assign bus.rst_done = r_done_q;

`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [1:0] r_cause_q;

  // Watchdog wins when both requests arrive on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cause_q <= 2'b00;
    end else if (bus.wdt_rst_req) begin
      r_cause_q <= 2'b10;
    end else if (bus.sw_rst_req) begin
      r_cause_q <= 2'b01;
    end
  end

  assign bus.rst_cause = r_cause_q;
`else
  assign bus.rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer at default parameters (3 domains, hold 16, stage 8).
// Expected rst_cause values follow the RESET_SEQUENCER_CAUSE_EN build option.
module tb_reset_sequencer;

  localparam int unsigned N = 3;
  localparam int unsigned H = 16;
  localparam int unsigned S = 8;

`ifdef RESET_SEQUENCER_CAUSE_EN
  localparam logic [1:0] CauseSw  = 2'b01;
  localparam logic [1:0] CauseWdt = 2'b10;
`else
  localparam logic [1:0] CauseSw  = 2'b00;
  localparam logic [1:0] CauseWdt = 2'b00;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reset_sequencer_if #(.N_DOMAINS(N)) bus ();

  reset_sequencer #(
    .N_DOMAINS  (N),
    .HOLD_CYCLES(H),
    .STAGE_DELAY(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.sw_rst_req  = 1'b0;
    bus.wdt_rst_req = 1'b0;
    rst_n           = 1'b0;
    step(4);
    n_tests++;
    if (bus.rst_out !== 3'b111) begin
      n_fail++; $display("FAIL reset_out: got %b want 111", bus.rst_out);
    end
    n_tests++;
    if (bus.rst_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.rst_done);
    end
    n_tests++;
    if (bus.rst_cause !== 2'b00) begin
      n_fail++; $display("FAIL reset_cause: got %b want 00", bus.rst_cause);
    end
  endtask

  task automatic test_power_on();
    logic [2:0] exp_out;
    rst_n = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      step(1);
      exp_out = (e < 16) ? 3'b111 : (e < 24) ? 3'b110 : (e < 32) ? 3'b100 : 3'b000;
      n_tests++;
      if (bus.rst_out !== exp_out || bus.rst_done !== (e >= 32)) begin
        n_fail++;
        $display("FAIL power_on edge %0d: got out=%b done=%b want out=%b done=%b",
                 e, bus.rst_out, bus.rst_done, exp_out, (e >= 32));
      end
    end
    n_tests++;
    if (bus.rst_cause !== 2'b00) begin
      n_fail++; $display("FAIL power_on_cause: got %b want 00", bus.rst_cause);
    end
  endtask

  task automatic test_sw_in_run();
    logic [2:0] exp_out;
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    n_tests++;
    if (bus.rst_out !== 3'b111 || bus.rst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_assert: got out=%b done=%b want out=111 done=0",
               bus.rst_out, bus.rst_done);
    end
    n_tests++;
    if (bus.rst_cause !== CauseSw) begin
      n_fail++; $display("FAIL sw_cause: got %b want %b", bus.rst_cause, CauseSw);
    end
    for (int e = 1; e <= 33; e++) begin
      step(1);
      exp_out = (e < 16) ? 3'b111 : (e < 24) ? 3'b110 : (e < 32) ? 3'b100 : 3'b000;
      n_tests++;
      if (bus.rst_out !== exp_out || bus.rst_done !== (e >= 32)) begin
        n_fail++;
        $display("FAIL sw_seq edge k+%0d: got out=%b done=%b want out=%b done=%b",
                 e, bus.rst_out, bus.rst_done, exp_out, (e >= 32));
      end
    end
  endtask

  task automatic test_wdt_in_release();
    logic [2:0] exp_out;
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    step(18);
    n_tests++;
    if (bus.rst_out !== 3'b110) begin
      n_fail++; $display("FAIL wdt_pre_release: got %b want 110", bus.rst_out);
    end
    bus.wdt_rst_req = 1'b1;
    step(1);
    bus.wdt_rst_req = 1'b0;
    n_tests++;
    if (bus.rst_out !== 3'b111 || bus.rst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL wdt_assert: got out=%b done=%b want out=111 done=0",
               bus.rst_out, bus.rst_done);
    end
    n_tests++;
    if (bus.rst_cause !== CauseWdt) begin
      n_fail++; $display("FAIL wdt_cause: got %b want %b", bus.rst_cause, CauseWdt);
    end
    for (int e = 1; e <= 33; e++) begin
      step(1);
      exp_out = (e < 16) ? 3'b111 : (e < 24) ? 3'b110 : (e < 32) ? 3'b100 : 3'b000;
      n_tests++;
      if (bus.rst_out !== exp_out || bus.rst_done !== (e >= 32)) begin
        n_fail++;
        $display("FAIL wdt_seq edge k+%0d: got out=%b done=%b want out=%b done=%b",
                 e, bus.rst_out, bus.rst_done, exp_out, (e >= 32));
      end
    end
  endtask

  task automatic test_hold_restart();
    logic [2:0] exp_out;
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    step(10);
    n_tests++;
    if (bus.rst_out !== 3'b111) begin
      n_fail++; $display("FAIL hold_mid: got %b want 111", bus.rst_out);
    end
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    n_tests++;
    if (bus.rst_cause !== CauseSw) begin
      n_fail++; $display("FAIL hold_cause: got %b want %b", bus.rst_cause, CauseSw);
    end
    for (int e = 1; e <= 33; e++) begin
      step(1);
      exp_out = (e < 16) ? 3'b111 : (e < 24) ? 3'b110 : (e < 32) ? 3'b100 : 3'b000;
      n_tests++;
      if (bus.rst_out !== exp_out || bus.rst_done !== (e >= 32)) begin
        n_fail++;
        $display("FAIL hold_seq edge k+%0d: got out=%b done=%b want out=%b done=%b",
                 e, bus.rst_out, bus.rst_done, exp_out, (e >= 32));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_out;
    bus.sw_rst_req  = 1'b1;
    bus.wdt_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_tests++;
      if (bus.rst_out !== 3'b111 || bus.rst_done !== 1'b0 || bus.rst_cause !== CauseWdt) begin
        n_fail++;
        $display("FAIL both_level %0d: got out=%b done=%b cause=%b want out=111 done=0 cause=%b",
                 i, bus.rst_out, bus.rst_done, bus.rst_cause, CauseWdt);
      end
    end
    bus.sw_rst_req  = 1'b0;
    bus.wdt_rst_req = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      step(1);
      exp_out = (e < 16) ? 3'b111 : (e < 24) ? 3'b110 : (e < 32) ? 3'b100 : 3'b000;
      n_tests++;
      if (bus.rst_out !== exp_out || bus.rst_done !== (e >= 32)) begin
        n_fail++;
        $display("FAIL both_seq edge L+%0d: got out=%b done=%b want out=%b done=%b",
                 e, bus.rst_out, bus.rst_done, exp_out, (e >= 32));
      end
    end
  endtask

  task automatic test_rst_n_mid();
    logic [2:0] exp_out;
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    step(24);
    n_tests++;
    if (bus.rst_out !== 3'b100) begin
      n_fail++; $display("FAIL mid_pre: got %b want 100", bus.rst_out);
    end
    // rst_n must win over a simultaneous watchdog request.
    rst_n           = 1'b0;
    bus.wdt_rst_req = 1'b1;
    step(1);
    rst_n           = 1'b1;
    bus.wdt_rst_req = 1'b0;
    n_tests++;
    if (bus.rst_out !== 3'b111 || bus.rst_done !== 1'b0 || bus.rst_cause !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: got out=%b done=%b cause=%b want out=111 done=0 cause=00",
               bus.rst_out, bus.rst_done, bus.rst_cause);
    end
    for (int e = 1; e <= 33; e++) begin
      step(1);
      exp_out = (e < 16) ? 3'b111 : (e < 24) ? 3'b110 : (e < 32) ? 3'b100 : 3'b000;
      n_tests++;
      if (bus.rst_out !== exp_out || bus.rst_done !== (e >= 32)) begin
        n_fail++;
        $display("FAIL mid_seq edge %0d: got out=%b done=%b want out=%b done=%b",
                 e, bus.rst_out, bus.rst_done, exp_out, (e >= 32));
      end
    end
    n_tests++;
    if (bus.rst_cause !== 2'b00) begin
      n_fail++; $display("FAIL mid_cause_end: got %b want 00", bus.rst_cause);
    end
  endtask

  initial begin
    bus.sw_rst_req  = 1'b0;
    bus.wdt_rst_req = 1'b0;
    test_reset();
    test_power_on();
    test_sw_in_run();
    test_wdt_in_release();
    test_hold_restart();
    test_simultaneous();
    test_rst_n_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
